serial_add_sub: RTL



---
 rtl/serial_add_sub.sv | 132 +++++++++++++
 1 files changed

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial add/subtract unit, one full-adder cell iterated LSB-first for WIDTH cycles.
// Optional macro SERIAL_ADD_SUB_FLAGS_EN adds registered ovf/zero flag outputs.
`default_nettype none

module serial_add_sub #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADD_SUB_FLAGS_EN
  ,
  output logic             ovf,
  output logic             zero
`endif
);

  localparam int                CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-2:0] r_r;
  logic             r_c;
  logic             r_sub;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_cat;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_c    = (r_a[0] & r_b[0]) | ((r_a[0] ^ r_b[0]) & r_c);
  assign w_last = (r_state == S_RUN) && (r_cnt == C_LAST);
  // On the last RUN cycle this concatenation is the complete sum.
  assign w_cat  = {w_s, r_r};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_cnt == C_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_r      <= '0;
      r_c      <= 1'b0;
      r_sub    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else begin
      if (r_state == S_IDLE && start) begin
        r_a   <= a;
        r_b   <= sub ? ~b : b;
        r_c   <= sub ? ~cin : cin;
        r_sub <= sub;
        r_cnt <= '0;
      end
      if (r_state == S_RUN) begin
        r_a   <= r_a >> 1;
        r_b   <= r_b >> 1;
        r_c   <= w_c;
        r_r   <= w_cat[WIDTH-1:1];
        r_cnt <= r_cnt + 1'b1;
      end
      // Outputs update only as the final bit is formed, so they never show partial sums.
      if (w_last) begin
        r_result <= w_cat;
        r_cout   <= w_c ^ r_sub;
      end
    end
  end

`ifdef SERIAL_ADD_SUB_FLAGS_EN
  logic r_ovf;
  logic r_zero;

  // r_c holds the carry into the MSB during the last RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_last) begin
      r_ovf  <= r_c ^ w_c;
      r_zero <= (w_cat == '0);
    end
  end

  assign ovf  = r_ovf;
  assign zero = r_zero;
`endif

  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_cout;

endmodule

`default_nettype wire
